// File: rtl/mac_grid.sv
// ============================================================================
// Module   : mac_grid
// Brief    : ROWS x COLS output-stationary systolic MAC array. A lanes enter
//            on the left and move right, B lanes enter on the top and move
//            down, and each PE(r,c) accumulates C[r][c]. Input skew, job
//            control and row-serial result drain are all internal.
// Config   : MAC_GRID_SAT_EN - when defined, every PE add saturates and any
//            clip raises the sticky sat_flag; when undefined, adds wrap and
//            sat_flag is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_grid #(
   parameter int W     = 8,
   parameter int ACC_W = 24,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int KW    = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   input  logic [KW-1:0]                              k_len,
   output logic                                       busy,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [ROWS*W-1:0]                          a_in,
   input  logic [COLS*W-1:0]                          w_in,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
   output logic [COLS*ACC_W-1:0]                      out_data,
   output logic                                       done,
   output logic                                       sat_flag
);

   localparam int c_row_w   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int c_flush_w = $clog2(ROWS + COLS);

   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_compute = 3'd1;
   localparam logic [2:0] c_st_flush   = 3'd2;
   localparam logic [2:0] c_st_drain   = 3'd3;
   localparam logic [2:0] c_st_done    = 3'd4;

   logic [2:0]           r_state;
   logic [KW-1:0]        r_k_len;
   logic [KW-1:0]        r_beat_cnt;
   logic [c_flush_w-1:0] r_flush_cnt;
   logic [c_row_w-1:0]   r_row;
   logic                 w_accept;
   logic                 w_clear;

   // PE input operands and their valid tags, indexed by destination PE
   logic [W-1:0]            w_pe_a  [ROWS][COLS];
   logic                    w_pe_av [ROWS][COLS];
   logic [W-1:0]            w_pe_w  [ROWS][COLS];
   logic                    w_pe_wv [ROWS][COLS];
   logic signed [ACC_W-1:0] w_acc_val [ROWS][COLS];

   // in_ready depends only on the registered state, never on in_valid
   assign in_ready  = (r_state == c_st_compute);
   assign w_accept  = in_valid & in_ready;
   assign w_clear   = (r_state == c_st_idle) & start;
   assign busy      = (r_state != c_st_idle);
   assign out_valid = (r_state == c_st_drain);
   assign done      = (r_state == c_st_done);
   assign out_row   = r_row;

   // Job control: accept k_len beats, let the wavefront flush, drain rows
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_st_idle;
         r_k_len     <= '0;
         r_beat_cnt  <= '0;
         r_flush_cnt <= '0;
         r_row       <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_k_len    <= k_len;
                  r_beat_cnt <= '0;
                  r_row      <= '0;
                  r_state    <= (k_len == '0) ? c_st_drain : c_st_compute;
               end
            end
            c_st_compute: begin
               if (w_accept) begin
                  if (r_beat_cnt == (r_k_len - KW'(1))) begin
                     r_flush_cnt <= '0;
                     r_state     <= c_st_flush;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + KW'(1);
                  end
               end
            end
            c_st_flush: begin
               // Last beat reaches PE(ROWS-1,COLS-1) ROWS+COLS-1 edges after its accept
               if (r_flush_cnt == c_flush_w'(ROWS + COLS - 2)) begin
                  r_state <= c_st_drain;
               end else begin
                  r_flush_cnt <= r_flush_cnt + c_flush_w'(1);
               end
            end
            c_st_drain: begin
               if (out_ready) begin
                  if (r_row == c_row_w'(ROWS - 1)) begin
                     r_row   <= '0;
                     r_state <= c_st_done;
                  end else begin
                     r_row <= r_row + c_row_w'(1);
                  end
               end
            end
            c_st_done: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

`ifdef MAC_GRID_SAT_EN
   logic w_clip [ROWS][COLS];
   logic w_any_clip;
   logic r_sat;

   // Collapse every PE clip indication into one event
   always_comb begin
      w_any_clip = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            w_any_clip = w_any_clip | w_clip[i][j];
         end
      end
   end

   // Sticky per-job saturation flag, cleared when a new job starts
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (w_clear) begin
         r_sat <= 1'b0;
      end else if (w_any_clip) begin
         r_sat <= 1'b1;
      end
   end

   assign sat_flag = r_sat;
`else
   assign sat_flag = 1'b0;
`endif

   // A lane r is delayed r cycles before entering PE(r,0)
   for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      logic [W-1:0] r_sk   [0:r];
      logic         r_sk_v [0:r];

      // Shift the lane value and its valid tag through the skew stages
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= r; j++) begin
               r_sk[j]   <= '0;
               r_sk_v[j] <= 1'b0;
            end
         end else begin
            r_sk[0]   <= a_in[r*W +: W];
            r_sk_v[0] <= w_accept;
            for (int j = 1; j <= r; j++) begin
               r_sk[j]   <= r_sk[j-1];
               r_sk_v[j] <= r_sk_v[j-1];
            end
         end
      end

      assign w_pe_a[r][0]  = r_sk[r];
      assign w_pe_av[r][0] = r_sk_v[r];
   end

   // B lane c is delayed c cycles before entering PE(0,c)
   for (genvar c = 0; c < COLS; c++) begin : g_w_skew
      logic [W-1:0] r_sk   [0:c];
      logic         r_sk_v [0:c];

      // Shift the lane value and its valid tag through the skew stages
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= c; j++) begin
               r_sk[j]   <= '0;
               r_sk_v[j] <= 1'b0;
            end
         end else begin
            r_sk[0]   <= w_in[c*W +: W];
            r_sk_v[0] <= w_accept;
            for (int j = 1; j <= c; j++) begin
               r_sk[j]   <= r_sk[j-1];
               r_sk_v[j] <= r_sk_v[j-1];
            end
         end
      end

      assign w_pe_w[0][c]  = r_sk[c];
      assign w_pe_wv[0][c] = r_sk_v[c];
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic                    w_fire;
         logic signed [2*W-1:0]   w_prod;
         logic signed [ACC_W-1:0] w_prod_ext;
         logic signed [ACC_W-1:0] w_next;
         logic signed [ACC_W-1:0] r_acc;

         // Bubbles carry a zero tag on at least one side and never accumulate
         assign w_fire     = w_pe_av[r][c] & w_pe_wv[r][c];
         assign w_prod     = (2*W)'($signed(w_pe_a[r][c])) * (2*W)'($signed(w_pe_w[r][c]));
         assign w_prod_ext = ACC_W'(w_prod);

`ifdef MAC_GRID_SAT_EN
         logic signed [ACC_W:0] w_wide;
         logic                  w_ovf;

         assign w_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
         assign w_ovf  = (w_wide[ACC_W] != w_wide[ACC_W-1]);
         assign w_clip[r][c] = w_fire & w_ovf;

         // Clamp to the most negative or most positive accumulator value
         always_comb begin
            w_next = w_wide[ACC_W-1:0];
            if (w_ovf) begin
               w_next = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
            end
         end
`else
         assign w_next = r_acc + w_prod_ext;
`endif

         // Output-stationary accumulator, cleared at the start of each job
         always_ff @(posedge clk) begin
            if (rst) begin
               r_acc <= '0;
            end else if (w_clear) begin
               r_acc <= '0;
            end else if (w_fire) begin
               r_acc <= w_next;
            end
         end

         assign w_acc_val[r][c] = r_acc;

         if (c < COLS - 1) begin : g_fwd_a
            logic [W-1:0] r_fwd_a;
            logic         r_fwd_av;

            // Pass the A operand one PE to the right
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_fwd_a  <= '0;
                  r_fwd_av <= 1'b0;
               end else begin
                  r_fwd_a  <= w_pe_a[r][c];
                  r_fwd_av <= w_pe_av[r][c];
               end
            end

            assign w_pe_a[r][c+1]  = r_fwd_a;
            assign w_pe_av[r][c+1] = r_fwd_av;
         end

         if (r < ROWS - 1) begin : g_fwd_w
            logic [W-1:0] r_fwd_w;
            logic         r_fwd_wv;

            // Pass the B operand one PE down
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_fwd_w  <= '0;
                  r_fwd_wv <= 1'b0;
               end else begin
                  r_fwd_w  <= w_pe_w[r][c];
                  r_fwd_wv <= w_pe_wv[r][c];
               end
            end

            assign w_pe_w[r+1][c]  = r_fwd_w;
            assign w_pe_wv[r+1][c] = r_fwd_wv;
         end
      end
   end

   // Present the accumulators of the row selected by the drain counter
   always_comb begin
      out_data = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (r_row == c_row_w'(i)) begin
            for (int j = 0; j < COLS; j++) begin
               out_data[j*ACC_W +: ACC_W] = w_acc_val[i][j];
            end
         end
      end
   end

endmodule

`default_nettype wire
